// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 2-FF input synchroniser, break handling and a
// show-ahead byte FIFO drained through a valid/ready port.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_rxd,
  output logic [7:0]                      o_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
  output logic                            o_busy,
  output logic                            o_frame_err,
  output logic                            o_overrun
);

  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT/2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state;
  logic            rxd_m, rxd_s;
  logic [CNTW-1:0] clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push_req, push_ok, pop, full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      case (state)
        IDLE: if (!rxd_s) begin
          state   <= START;
          clk_cnt <= '0;
        end
        // Half-bit re-check rejects glitches shorter than half a bit.
        START: if (clk_cnt == HALF_LAST) begin
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= rxd_s ? IDLE : DATA;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
        DATA: if (clk_cnt == BIT_LAST) begin
          clk_cnt        <= '0;
          shift[bit_idx] <= rxd_s;
          if (bit_idx == 3'd7) state <= STOP;
          else                 bit_idx <= bit_idx + 3'd1;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
        STOP: if (clk_cnt == BIT_LAST) begin
          clk_cnt <= '0;
          if (rxd_s) begin
            state <= IDLE;
          end else begin
            o_frame_err <= 1'b1;
            state       <= BREAK;
          end
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
        // Wait out a held-low line so it reports a single framing error.
        BREAK: if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy   = (state != IDLE);
  assign push_req = (state == STOP) && (clk_cnt == BIT_LAST) && rxd_s;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = o_valid & i_ready;
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      o_overrun <= push_req & full & ~pop;
      if (push_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_valid = (count != '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one instance at 1250 clk/bit, one at 16.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s, rst_f, line_s, line_f, rdy_s, rdy_f;
  logic [7:0] data_s, data_f;
  logic [2:0] count_s, count_f;
  logic       valid_s, valid_f, busy_s, busy_f, fe_s, fe_f, ov_s, ov_f;

  int checks = 0;
  int errors = 0;
  int fe_n_s = 0, ov_n_s = 0, fe_n_f = 0, ov_n_f = 0, both_n = 0;
  logic [7:0] q_s[$];
  logic [7:0] q_f[$];

  uart_rx_fifo #(.CLKS_PER_BIT(1250), .FIFO_DEPTH(4)) u_slow (
    .clk(clk), .rst(rst_s), .i_rxd(line_s), .o_data(data_s), .o_valid(valid_s),
    .i_ready(rdy_s), .o_count(count_s), .o_busy(busy_s), .o_frame_err(fe_s),
    .o_overrun(ov_s));

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u_fast (
    .clk(clk), .rst(rst_f), .i_rxd(line_f), .o_data(data_f), .o_valid(valid_f),
    .i_ready(rdy_f), .o_count(count_f), .o_busy(busy_f), .o_frame_err(fe_f),
    .o_overrun(ov_f));

  always @(posedge clk) begin
    if (fe_s) fe_n_s <= fe_n_s + 1;
    if (ov_s) ov_n_s <= ov_n_s + 1;
    if (fe_f) fe_n_f <= fe_n_f + 1;
    if (ov_f) ov_n_f <= ov_n_f + 1;
    if ((fe_s && ov_s) || (fe_f && ov_f)) both_n <= both_n + 1;
  end

  // Hold the line at v for n bit-clocks; entered and left just after a posedge.
  task automatic line_drive(input bit fast, input bit v, input int n);
    if (fast) line_f = v; else line_s = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit fast, input logic [7:0] b, input bit stop);
    int cpb = fast ? 16 : 1250;
    line_drive(fast, 1'b0, cpb);
    for (int i = 0; i < 8; i++) line_drive(fast, b[i], cpb);
    line_drive(fast, stop, cpb);
  endtask

  task automatic drain(input bit fast);
    int guard = 0;
    logic [7:0] exp_b;
    logic [7:0] act_b;
    @(negedge clk);
    while ((fast ? q_f.size() : q_s.size()) != 0 && guard < 50) begin
      if (fast ? valid_f : valid_s) begin
        if (fast) exp_b = q_f.pop_front(); else exp_b = q_s.pop_front();
        act_b = fast ? data_f : data_s;
        checks++;
        if (act_b !== exp_b) begin
          errors++;
          $display("FAIL drain_data fast=%0d actual=%h required=%h", fast, act_b, exp_b);
        end
        if (fast) rdy_f = 1'b1; else rdy_s = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    rdy_f = 1'b0;
    rdy_s = 1'b0;
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL drain_timeout fast=%0d actual=%0d left required=0", fast,
               fast ? q_f.size() : q_s.size());
    end
    checks++;
    if ((fast ? valid_f : valid_s) !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty fast=%0d actual=%b required=0", fast, fast ? valid_f : valid_s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_s = 0; rst_f = 0; line_s = 1; line_f = 1; rdy_s = 0; rdy_f = 0;
    #2;
    rst_s = 1; rst_f = 1;
    #1;
    for (int f = 0; f < 2; f++) begin
      checks++;
      if ((f ? {data_f, valid_f, count_f, busy_f, fe_f, ov_f}
             : {data_s, valid_s, count_s, busy_s, fe_s, ov_s}) !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs fast=%0d actual=%h required=0", f,
                 f ? {data_f, valid_f, count_f, busy_f, fe_f, ov_f}
                   : {data_s, valid_s, count_s, busy_s, fe_s, ov_s});
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst_s = 0; rst_f = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame_slow;
    q_s.push_back(8'h61);
    fork
      send_frame(1'b0, 8'h61, 1'b1);
      begin
        repeat (2) @(posedge clk); #1;
        checks++;
        if (busy_s !== 1'b0) begin errors++; $display("FAIL busy_early actual=%b required=0", busy_s); end
        @(posedge clk); #1;
        checks++;
        if (busy_s !== 1'b1) begin errors++; $display("FAIL busy_rise actual=%b required=1", busy_s); end
        repeat (11874) @(posedge clk); #1;
        checks++;
        if (valid_s !== 1'b0) begin errors++; $display("FAIL valid_early actual=%b required=0", valid_s); end
        @(posedge clk); #1;
        checks++;
        if ({valid_s, data_s, count_s} !== {1'b1, 8'h61, 3'd1}) begin
          errors++;
          $display("FAIL latency_push actual=%b/%h/%0d required=1/61/1", valid_s, data_s, count_s);
        end
      end
    join
    checks++;
    if (fe_n_s != 0 || ov_n_s != 0) begin
      errors++; $display("FAIL frame_slow_pulses actual=%0d/%0d required=0/0", fe_n_s, ov_n_s);
    end
    drain(1'b0);
  endtask

  task automatic test_glitch;
    int fe0 = fe_n_s;
    fork
      begin line_drive(1'b0, 1'b0, 300); line_drive(1'b0, 1'b1, 400); end
      begin
        repeat (627) @(posedge clk); #1;
        checks++;
        if (busy_s !== 1'b1) begin errors++; $display("FAIL glitch_busy actual=%b required=1", busy_s); end
        @(posedge clk); #1;
        checks++;
        if (busy_s !== 1'b0) begin errors++; $display("FAIL glitch_idle actual=%b required=0", busy_s); end
      end
    join
    checks++;
    if (valid_s !== 1'b0 || fe_n_s != fe0) begin
      errors++; $display("FAIL glitch_quiet actual=%b/%0d required=0/0", valid_s, fe_n_s - fe0);
    end
  endtask

  task automatic test_framing_break;
    int fe0 = fe_n_f;
    int ov0 = ov_n_f;
    send_frame(1'b1, 8'h55, 1'b0);
    line_drive(1'b1, 1'b0, 2000);
    line_drive(1'b1, 1'b1, 40);
    checks++;
    if (fe_n_f - fe0 != 1) begin errors++; $display("FAIL frame_err_count actual=%0d required=1", fe_n_f - fe0); end
    checks++;
    if (valid_f !== 1'b0 || count_f !== 3'd0) begin
      errors++; $display("FAIL no_push_55 actual=%b/%0d required=0/0", valid_f, count_f);
    end
    q_f.push_back(8'hA3);
    send_frame(1'b1, 8'hA3, 1'b1);
    line_drive(1'b1, 1'b1, 8);
    checks++;
    if (fe_n_f - fe0 != 1 || ov_n_f != ov0) begin
      errors++; $display("FAIL after_break_pulses actual=%0d/%0d required=1/0", fe_n_f - fe0, ov_n_f - ov0);
    end
    drain(1'b1);
  endtask

  task automatic test_overrun;
    int fe0 = fe_n_f;
    int ov0 = ov_n_f;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) q_f.push_back(8'(b));
      send_frame(1'b1, 8'(b), 1'b1);
    end
    line_drive(1'b1, 1'b1, 4);
    checks++;
    if (count_f !== 3'd4) begin errors++; $display("FAIL overrun_count actual=%0d required=4", count_f); end
    checks++;
    if (ov_n_f - ov0 != 1 || fe_n_f != fe0) begin
      errors++; $display("FAIL overrun_pulses actual=%0d/%0d required=1/0", ov_n_f - ov0, fe_n_f - fe0);
    end
    drain(1'b1);
  endtask

  task automatic test_full_pop;
    int ov0 = ov_n_f;
    for (int b = 8'h10; b <= 8'h13; b++) begin
      q_f.push_back(8'(b));
      send_frame(1'b1, 8'(b), 1'b1);
    end
    checks++;
    if (count_f !== 3'd4) begin errors++; $display("FAIL full_count actual=%0d required=4", count_f); end
    q_f.push_back(8'h14);
    fork
      send_frame(1'b1, 8'h14, 1'b1);
      begin
        // Stop sample of this frame lands on the 155th edge.
        repeat (154) @(posedge clk); #1;
        checks++;
        if (data_f !== q_f[0]) begin errors++; $display("FAIL head_before_pop actual=%h required=%h", data_f, q_f[0]); end
        void'(q_f.pop_front());
        rdy_f = 1'b1;
        @(posedge clk); #1;
        rdy_f = 1'b0;
        checks++;
        if (count_f !== 3'd4) begin errors++; $display("FAIL full_pop_count actual=%0d required=4", count_f); end
      end
    join
    checks++;
    if (ov_n_f != ov0) begin errors++; $display("FAIL full_pop_overrun actual=%0d required=0", ov_n_f - ov0); end
    drain(1'b1);
  endtask

  task automatic test_reset_midframe;
    int fe0, ov0;
    send_frame(1'b1, 8'h5A, 1'b1);
    fe0 = fe_n_f;
    ov0 = ov_n_f;
    fork
      send_frame(1'b1, 8'h7E, 1'b1);
      begin
        repeat (85) @(posedge clk); #1;
        rst_f = 1'b1;
        #1;
        checks++;
        if ({data_f, valid_f, count_f, busy_f, fe_f, ov_f} !== 15'd0) begin
          errors++;
          $display("FAIL midframe_reset actual=%h required=0", {data_f, valid_f, count_f, busy_f, fe_f, ov_f});
        end
        repeat (80) @(posedge clk); #1;
        rst_f = 1'b0;
      end
    join
    q_f.push_back(8'hC3);
    send_frame(1'b1, 8'hC3, 1'b1);
    line_drive(1'b1, 1'b1, 4);
    checks++;
    if (valid_f !== 1'b1 || data_f !== 8'hC3) begin
      errors++; $display("FAIL after_reset_rx actual=%b/%h required=1/c3", valid_f, data_f);
    end
    checks++;
    if (fe_n_f != fe0 || ov_n_f != ov0) begin
      errors++; $display("FAIL after_reset_pulses actual=%0d/%0d required=0/0", fe_n_f - fe0, ov_n_f - ov0);
    end
    drain(1'b1);
  endtask

  initial begin
    test_reset();
    test_frame_slow();
    test_glitch();
    test_framing_break();
    test_overrun();
    test_full_pop();
    test_reset_midframe();
    checks++;
    if (both_n != 0) begin errors++; $display("FAIL err_overlap actual=%0d required=0", both_n); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
